// File: rtl/csa_mp_seq_pkg.sv
// Shared constants for the multi-precision add/subtract sequencer:
// slice width and FSM state encoding.
package csa_mp_seq_pkg;

    localparam int SLICE_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/csa_mp_seq_csa_16.sv
// 16-bit slice adder with carry in/out, time-multiplexed by csa_mp_seq.
module csa_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [16:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {16'b0, c_in};
    assign sum   = total[15:0];
    assign c_out = total[16];

endmodule

// File: rtl/csa_mp_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS 16-bit slices through one
// csa_16, least-significant first, chaining the carry through a register.
module csa_mp_seq
    import csa_mp_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       c_in,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       c_out,
    output logic                       ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] a_sl, b_sl, csa_sum;
    logic               csa_co;

    // Signed overflow: like-signed operands producing a result of the other sign.
    function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                a_sl = a_q[w*SLICE_W +: SLICE_W];
                b_sl = b_q[w*SLICE_W +: SLICE_W];
            end
        end
    end

    csa_16 u_csa (
        .a     (a_sl),
        .b     (b_sl),
        .c_in  (carry_q),
        .sum   (csa_sum),
        .c_out (csa_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : c_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        sum_d[w*SLICE_W +: SLICE_W] = csa_sum;
                    end
                end
                carry_d = csa_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    c_out_d = csa_co;
                    ovf_d   = ovf_of(a_sl[SLICE_W-1], b_sl[SLICE_W-1], csa_sum[SLICE_W-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand and carry registers are only meaningful once loaded in IDLE.
    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        carry_q <= carry_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_mp_seq.sv
// Directed and randomised checks of csa_mp_seq at WORDS=4 and WORDS=1.
module tb_csa_mp_seq;

    logic clk;
    logic rst_n;

    logic        in_valid_4, in_ready_4, c_in_4, op_sub_4, out_valid_4, out_ready_4, c_out_4, ovf_4;
    logic [63:0] a_4, b_4, sum_4;
    logic        in_valid_1, in_ready_1, c_in_1, op_sub_1, out_valid_1, out_ready_1, c_out_1, ovf_1;
    logic [15:0] a_1, b_1, sum_1;

    int          cur_w;
    logic        rdy_m, ovld_m, co_m, ov_m;
    logic [63:0] sum_m;

    int n_checks;
    int n_fail;

    csa_mp_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a_4), .b(b_4), .c_in(c_in_4), .op_sub(op_sub_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .sum(sum_4), .c_out(c_out_4), .ovf(ovf_4)
    );

    csa_mp_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .a(a_1), .b(b_1), .c_in(c_in_1), .op_sub(op_sub_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1),
        .sum(sum_1), .c_out(c_out_1), .ovf(ovf_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (cur_w == 4) begin
            rdy_m  = in_ready_4;
            ovld_m = out_valid_4;
            sum_m  = sum_4;
            co_m   = c_out_4;
            ov_m   = ovf_4;
        end else begin
            rdy_m  = in_ready_1;
            ovld_m = out_valid_1;
            sum_m  = {48'b0, sum_1};
            co_m   = c_out_1;
            ov_m   = ovf_1;
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [63:0] av, input logic [63:0] bv,
                          input logic cin, input logic sub);
        if (w == 4) begin
            in_valid_4 = v; a_4 = av; b_4 = bv; c_in_4 = cin; op_sub_4 = sub;
        end else begin
            in_valid_1 = v; a_1 = av[15:0]; b_1 = bv[15:0]; c_in_1 = cin; op_sub_1 = sub;
        end
    endtask

    task automatic set_ordy(input int w, input logic v);
        if (w == 4) out_ready_4 = v;
        else        out_ready_1 = v;
    endtask

    // Full-width reference: {c_out,sum} = a + (sub ? ~b : b) + (sub ? 1 : c_in), truncated to 16*w bits.
    task automatic ref_op(input int w, input logic [63:0] av, input logic [63:0] bv, input logic cin,
                          input logic sub, output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] mask, aa, bb;
        logic [64:0] t;
        int m;
        mask = (w == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
        aa   = av & mask;
        bb   = (sub ? ~bv : bv) & mask;
        t    = {1'b0, aa} + {1'b0, bb} + {64'b0, (sub ? 1'b1 : cin)};
        m    = 16 * w - 1;
        s    = t[63:0] & mask;
        co   = t[m+1];
        ov   = (aa[m] == bb[m]) && (t[m] != aa[m]);
    endtask

    task automatic do_op(input int w, input logic [63:0] av, input logic [63:0] bv, input logic cin,
                         input logic sub, input int stall, output logic [63:0] s, output logic co,
                         output logic ov, output int lat);
        int n;
        cur_w = w;
        set_in(w, 1'b1, av, bv, cin, sub);
        n = 0;
        #0;
        while (!rdy_m && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        set_in(w, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        lat = 0;
        while (!ovld_m && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        s  = sum_m;
        co = co_m;
        ov = ov_m;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check_val("ovld_drop", {127'b0, ovld_m}, 128'd0);
    endtask

    typedef struct {
        int          w;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] es;
        logic        eco;
        logic        eov;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] s, rs, s0;
        logic        co, ov, rco, rov, seen;
        int          lat;

        n_checks = 0;
        n_fail   = 0;
        cur_w    = 4;
        rst_n    = 1'b0;
        set_in(4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        set_in(1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        out_ready_4 = 1'b0;
        out_ready_1 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready4",  {127'b0, in_ready_4},  128'd1);
        check_val("rst_out_valid4", {127'b0, out_valid_4}, 128'd0);
        check_val("rst_sum4",       {64'b0, sum_4},        128'd0);
        check_val("rst_cout_ovf4",  {126'b0, c_out_4, ovf_4}, 128'd0);
        check_val("rst_in_ready1",  {127'b0, in_ready_1},  128'd1);
        check_val("rst_sum1",       {112'b0, sum_1},       128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed results
        vecs[0] = '{4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{4, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{4, 64'h0000_0001_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0001_0000, 1'b0, 1'b0};
        vecs[4] = '{1, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[5] = '{1, 64'h0000_0000_0000_8000, 64'd1, 1'b1, 1'b1, 64'h0000_0000_0000_7FFF, 1'b1, 1'b1};
        foreach (vecs[i]) begin
            do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, i % 3, s, co, ov, lat);
            check_val($sformatf("dir%0d_sum", i), {64'b0, s}, {64'b0, vecs[i].es});
            check_val($sformatf("dir%0d_cout", i), {127'b0, co}, {127'b0, vecs[i].eco});
            check_val($sformatf("dir%0d_ovf", i), {127'b0, ov}, {127'b0, vecs[i].eov});
            check_val($sformatf("dir%0d_lat", i), 128'(lat), 128'(vecs[i].w));
        end

        // Back-pressure with in_valid held high in DONE
        cur_w = 4;
        set_in(4, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(4, 1'b1, 64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        lat = 0;
        while (!out_valid_4 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check_val("bp_lat", 128'(lat), 128'd4);
        check_val("bp_sum", {64'b0, sum_4}, {64'b0, 64'h2345_6789_ABCD_F001});
        s0 = sum_4;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_val("bp_hold_sum", {64'b0, sum_4}, {64'b0, s0});
            check_val("bp_hold_rdy_vld", {126'b0, in_ready_4, out_valid_4}, 128'b01);
        end
        out_ready_4 = 1'b1;
        @(posedge clk); #1;
        out_ready_4 = 1'b0;
        check_val("bp_release", {126'b0, in_ready_4, out_valid_4}, 128'b10);
        @(posedge clk); #1;
        set_in(4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check_val("bp_next_taken", {127'b0, in_ready_4}, 128'd0);
        lat = 0;
        while (!out_valid_4 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check_val("bp_next_lat", 128'(lat), 128'd4);
        check_val("bp_next_sum", {64'b0, sum_4}, {64'b0, 64'h0000_0001_0001_0000});
        out_ready_4 = 1'b1;
        @(posedge clk); #1;
        out_ready_4 = 1'b0;

        // Asynchronous reset in the middle of RUN
        set_in(4, 1'b1, 64'h1, 64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(4, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_in_ready", {127'b0, in_ready_4}, 128'd1);
        check_val("midrst_out_valid", {127'b0, out_valid_4}, 128'd0);
        check_val("midrst_sum", {64'b0, sum_4}, 128'd0);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid_4) seen = 1'b1;
        end
        check_val("midrst_no_valid", {127'b0, seen}, 128'd0);

        // Random sweep against the full-width reference
        for (int w = 4; w >= 1; w -= 3) begin
            for (int i = 0; i < 150; i++) begin
                logic [63:0] ra, rb;
                logic        rc, rsub;
                ra   = {$urandom, $urandom};
                rb   = {$urandom, $urandom};
                rc   = 1'($urandom_range(0, 1));
                rsub = 1'($urandom_range(0, 1));
                ref_op(w, ra, rb, rc, rsub, rs, rco, rov);
                do_op(w, ra, rb, rc, rsub, int'($urandom_range(0, 3)), s, co, ov, lat);
                check_val($sformatf("rnd_w%0d_res", w), {63'b0, co, s}, {63'b0, rco, rs});
                check_val($sformatf("rnd_w%0d_ovf", w), {127'b0, ov}, {127'b0, rov});
                check_val($sformatf("rnd_w%0d_lat", w), 128'(lat), 128'(w));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
